uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter (Tx) between N_REQ byte producers.
- Grants one requester at a time and latches its byte onto Tx d_in.
- Pulses tx_start, waits for tx_done, then enforces an inter-frame gap before the next grant.
- Includes a watchdog so a stalled Tx cannot lock out the requesters.

Parameters:
N_REQ, 2, number of requesters (2..8)
ID_W, 1, width of grant_id; must equal clog2(N_REQ)
GAP_CYC, 0, idle clocks after a frame before the next grant (0 = none)
TIMEOUT_CYC, 65535, max clocks in WAIT without tx_done before abort (16-bit counter)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active low
req  in  N_REQ  per-requester request level; bit i high means req_data slice i is valid
req_data  in  8*N_REQ  byte for requester i at bits [8i+7:8i]
ack  out  N_REQ  one-hot, one-cycle pulse: requester i's byte has been latched
grant_id  out  ID_W  index of the requester currently owning Tx
busy  out  1  high in any state other than IDLE
tx_d  out  8  byte to Tx d_in; held stable from latch until the frame ends
tx_start  out  1  one-cycle start pulse to Tx
tx_done  in  1  Tx frame-complete pulse
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; ack, grant_id, busy, tx_d, tx_start, err_timeout, counters all 0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts immediately; no ack or err is emitted; Tx is expected to be reset alongside.
- All outputs are registered.
- States: IDLE, START, WAIT, GAP (2-bit encoding).
- IDLE:
  - If any req bit is set, pick the first set bit scanning from last_grant+1 upward, wrapping modulo N_REQ.
  - At the edge: tx_d<=slice, grant_id<=i, last_grant<=i, ack<=onehot(i), state<=START.
  - If no req bit is set, stay in IDLE.
- START: tx_start=1 for exactly this cycle; cnt<=0; state<=WAIT. Latency from req sampled to tx_start high is 1 clock.
- WAIT:
  - cnt increments each clock.
  - tx_done=1 -> state<=GAP if GAP_CYC>0, else IDLE.
  - Watchdog: if cnt==TIMEOUT_CYC-1 and tx_done=0, pulse err_timeout and go to GAP (or IDLE per the rule above).
  - If tx_done and the timeout coincide, tx_done wins and there is no error.
- GAP: count GAP_CYC clocks, then go to IDLE. Requests are not sampled during GAP.
- tx_done outside WAIT is ignored.
- Requester contract:
  - Hold req and req_data until ack is seen.
  - Drop req, or present the next byte, in the cycle after ack.
  - req is only re-sampled in IDLE, at least 3 clocks after ack, so a still-high req there is a new byte.
- Fairness: with every requester asserting continuously, grants cycle 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- tx_d and grant_id keep the last value in IDLE; they are not cleared.
- Wrap-around: last_grant=N_REQ-1 scans from 0. A single active requester is granted back-to-back.

Decomposition:
- Shared header uart_defs.vh holds:
  - state encodings (ST_IDLE=0, ST_START=1, ST_WAIT=2, ST_GAP=3);
  - data width 8;
  - default TIMEOUT_CYC.
- Sub-module rr_arbiter: combinational, with inputs req[N_REQ] and last_grant[ID_W], outputs gnt_onehot and gnt_id.
- uart_tx_sched instantiates rr_arbiter and contains the FSM, counters and output registers. Integration ties tx_d/tx_start/tx_done to Tx d_in/tx_start/tx_done.

Test Plan:
1. Reset and single request:
   - Stimulus: rst_n=0 for 2 clocks, then req=2'b01 with data 0xF0; Tx model returns tx_done 20 clocks after tx_start.
   - Required: ack=01 one clock after req, tx_start one clock later with tx_d=0xF0, busy low 1 clock after tx_done.
2. Round-robin contention:
   - Stimulus: req=2'b11 held, data0=0x55, data1=0xAA, each requester presents a new byte after its ack.
   - Required: tx_d sequence 0x55,0xAA,0x55,0xAA and grant_id 0,1,0,1.
3. Gap enforcement:
   - Stimulus: GAP_CYC=4, req0 held continuously.
   - Required: exactly 4 clocks in GAP plus 1 IDLE between tx_done and the next ack; no ack during GAP.
4. Watchdog:
   - Stimulus: TIMEOUT_CYC=10, Tx model never pulses tx_done.
   - Required: err_timeout pulses once 10 clocks after tx_start; FSM returns to IDLE and serves the next req.
5. Coincident done and timeout:
   - Stimulus: tx_done asserted on the cycle cnt==TIMEOUT_CYC-1.
   - Required: err_timeout stays 0 and the next frame proceeds normally.
6. Stray done and mid-frame reset:
   - Stimulus (a): tx_done pulsed while in IDLE. Required: ignored, no state change.
   - Stimulus (b): rst_n=0 during WAIT. Required: next clock shows state IDLE with all outputs 0, and requester 0 wins the next contention.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, widths, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_sched_pkg;

    localparam int DATA_W      = 8;
    localparam int CNT_W       = 16;
    localparam int TIMEOUT_DEF = 65535;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Requester index reached by stepping 'off' places past 'base', wrapping at n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first set req bit strictly after last_grant, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
module rr_arbiter
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]  gnt_id
);

    logic [ID_W-1:0] idx;
    logic            found;

    // Scan offsets 1..N_REQ so last_grant itself is considered last.
    always_comb begin
        gnt_onehot = '0;
        gnt_id     = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'(wrap_idx(int'(last_grant), k, N_REQ));
            if (!found && req[idx]) begin
                found      = 1'b1;
                gnt_id     = idx;
                gnt_onehot = N_REQ'(1) << idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART Tx among N_REQ byte producers, round-robin, with gap and watchdog.
// Latency: ack 1 clk after req sampled in IDLE, tx_start 1 clk after ack; all outputs registered.
// Backpressure: requesters hold req/req_data until ack; requests ignored outside IDLE.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int ID_W        = 1,
    parameter int GAP_CYC     = 0,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      ack,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy,
    output logic [DATA_W-1:0]     tx_d,
    output logic                  tx_start,
    input  logic                  tx_done,
    output logic                  err_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
    localparam state_e           ST_AFTER     = (GAP_CYC > 0) ? ST_GAP : ST_IDLE;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_grant_q, last_grant_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;
    logic [DATA_W-1:0] tx_d_q, tx_d_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              tx_start_q, tx_start_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  gap_q, gap_d;

    logic [N_REQ-1:0]  gnt_onehot;
    logic [ID_W-1:0]   gnt_id;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot),
        .gnt_id     (gnt_id)
    );

    // Next-state and next-output logic; pulses default low, data/ids hold.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        tx_d_d       = tx_d_q;
        ack_d        = '0;
        tx_start_d   = 1'b0;
        err_d        = 1'b0;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (gnt_onehot[i]) begin
                            tx_d_d = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    grant_id_d   = gnt_id;
                    last_grant_d = gnt_id;
                    ack_d        = gnt_onehot;
                    state_d      = ST_START;
                end
            end
            ST_START: begin
                tx_start_d = 1'b1;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A done arriving on the last watchdog cycle still counts as success.
                if (tx_done) begin
                    state_d = ST_AFTER;
                    gap_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_AFTER;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset makes requester 0 first in line.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= ID_W'(N_REQ - 1);
            grant_id_q   <= '0;
            tx_d_q       <= '0;
            ack_q        <= '0;
            tx_start_q   <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_d_q       <= tx_d_d;
            ack_q        <= ack_d;
            tx_start_q   <= tx_start_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            gap_q        <= gap_d;
        end
    end

    assign ack         = ack_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign tx_d        = tx_d_q;
    assign tx_start    = tx_start_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: instance 0 uses defaults, instance 1 has GAP_CYC=4, TIMEOUT_CYC=10.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point too.
// Tx is modelled by hand-placed tx_done pulses.
module tb_uart_tx_sched;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0][1:0] req_s  = '0;
    logic [1:0][15:0] data_s = '0;
    logic [1:0]      done_s = '0;
    logic [1:0][1:0] ack_s;
    logic [1:0]      gid_s;
    logic [1:0]      busy_s;
    logic [1:0][7:0] txd_s;
    logic [1:0]      start_s;
    logic [1:0]      err_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_sched u_dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_s[0]),
        .req_data    (data_s[0]),
        .ack         (ack_s[0]),
        .grant_id    (gid_s[0]),
        .busy        (busy_s[0]),
        .tx_d        (txd_s[0]),
        .tx_start    (start_s[0]),
        .tx_done     (done_s[0]),
        .err_timeout (err_s[0])
    );

    uart_tx_sched #(
        .N_REQ       (2),
        .ID_W        (1),
        .GAP_CYC     (4),
        .TIMEOUT_CYC (10)
    ) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req_s[1]),
        .req_data    (data_s[1]),
        .ack         (ack_s[1]),
        .grant_id    (gid_s[1]),
        .busy        (busy_s[1]),
        .tx_d        (txd_s[1]),
        .tx_start    (start_s[1]),
        .tx_done     (done_s[1]),
        .err_timeout (err_s[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an ack, then verify grant, start pulse and latched byte,
    // then return tx_done after done_after further clocks.
    task automatic run_frame(input int d, input logic [1:0] exp_ack, input logic exp_gid,
                             input logic [7:0] exp_txd, input int done_after);
        int n = 0;
        while (ack_s[d] == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        chk("ack_seen", (n < 20), 1);
        chk("ack", ack_s[d], exp_ack);
        chk("grant_id", gid_s[d], exp_gid);
        tick();
        chk("tx_start", start_s[d], 1);
        chk("tx_d", txd_s[d], exp_txd);
        repeat (done_after) tick();
        done_s[d] = 1'b1;
        tick();
        done_s[d] = 1'b0;
    endtask

    task automatic chk_reset(input int d);
        chk("rst_ack", ack_s[d], 0);
        chk("rst_gid", gid_s[d], 0);
        chk("rst_busy", busy_s[d], 0);
        chk("rst_txd", txd_s[d], 0);
        chk("rst_start", start_s[d], 0);
        chk("rst_err", err_s[d], 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;

        // 1: reset then a single request from requester 0
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset(0);
        chk_reset(1);
        rst_n     = 1'b1;
        req_s[0]  = 2'b01;
        data_s[0] = 16'h00F0;
        tick();
        chk("t1_ack_lat", ack_s[0], 2'b01);
        chk("t1_busy", busy_s[0], 1);
        chk("t1_no_start", start_s[0], 0);
        req_s[0] = 2'b00;
        run_frame(0, 2'b01, 1'b0, 8'hF0, 20);
        chk("t1_busy_low", busy_s[0], 0);

        // 2: round-robin with both requesters held
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        req_s[0]  = 2'b11;
        data_s[0] = 16'hAA55;
        run_frame(0, 2'b01, 1'b0, 8'h55, 3);
        run_frame(0, 2'b10, 1'b1, 8'hAA, 3);
        run_frame(0, 2'b01, 1'b0, 8'h55, 3);
        run_frame(0, 2'b10, 1'b1, 8'hAA, 3);
        req_s[0] = 2'b00;

        // 3: gap enforcement on instance 1
        req_s[1]  = 2'b01;
        data_s[1] = 16'h0011;
        run_frame(1, 2'b01, 1'b0, 8'h11, 2);
        for (int i = 0; i < 4; i++) begin
            chk("t3_gap_busy", busy_s[1], 1);
            chk("t3_gap_noack", ack_s[1], 0);
            tick();
        end
        chk("t3_idle_busy", busy_s[1], 0);
        chk("t3_idle_noack", ack_s[1], 0);
        tick();
        chk("t3_next_ack", ack_s[1], 2'b01);
        data_s[1] = 16'h0022;

        // 4: watchdog, tx_done never returned
        tick();
        chk("t4_start", start_s[1], 1);
        chk("t4_txd", txd_s[1], 8'h11);
        n = 0;
        while (!err_s[1] && n < 30) begin
            tick();
            n++;
        end
        chk("t4_err_latency", n, 10);
        tick();
        chk("t4_err_pulse", err_s[1], 0);
        chk("t4_gap_busy", busy_s[1], 1);

        // 5: next request served; its done coincides with the last watchdog cycle
        run_frame(1, 2'b01, 1'b0, 8'h22, 9);
        chk("t5_no_err", err_s[1], 0);
        chk("t5_gap_busy", busy_s[1], 1);
        run_frame(1, 2'b01, 1'b0, 8'h22, 2);
        chk("t5_no_err2", err_s[1], 0);
        req_s[1] = 2'b00;

        // 6a: stray tx_done while idle
        done_s[0] = 1'b1;
        tick();
        done_s[0] = 1'b0;
        chk("t6_stray_busy", busy_s[0], 0);
        chk("t6_stray_ack", ack_s[0], 0);
        chk("t6_stray_start", start_s[0], 0);
        tick();
        chk("t6_stray_busy2", busy_s[0], 0);

        // 6b: reset during WAIT, then contention goes to requester 0
        req_s[0]  = 2'b01;
        data_s[0] = 16'h0077;
        tick();
        chk("t6_ack", ack_s[0], 2'b01);
        req_s[0] = 2'b00;
        tick();
        chk("t6_start", start_s[0], 1);
        tick();
        tick();
        chk("t6_wait_busy", busy_s[0], 1);
        rst_n = 1'b0;
        tick();
        chk_reset(0);
        rst_n     = 1'b1;
        req_s[0]  = 2'b11;
        data_s[0] = 16'hAA55;
        tick();
        chk("t6_rr_restart", ack_s[0], 2'b01);
        req_s[0] = 2'b00;
        tick();
        chk("t6_rr_txd", txd_s[0], 8'h55);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
